// File: rtl/ahb_master_mux_if.sv
// Bus bundle for the AHB master multiplexer: per-master request inputs, selected-slave
// responses and the shared bus outputs.
interface ahb_master_mux_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [MW-1:0]                          Hmaster;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] M_Haddr;
    logic [NUM_MASTERS-1:0][1:0]            M_Htrans;
    logic [NUM_MASTERS-1:0]                 M_Hwrite;
    logic [NUM_MASTERS-1:0][2:0]            M_Hsize;
    logic [NUM_MASTERS-1:0][2:0]            M_Hburst;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] M_Hwdata;
    logic                                   Hready_in;
    logic                                   Hresp_in;
    logic [DATA_WIDTH-1:0]                  Hrdata_in;

    logic [ADDR_WIDTH-1:0]                  Haddr;
    logic [1:0]                             Htrans;
    logic                                   Hwrite;
    logic [2:0]                             Hsize;
    logic [2:0]                             Hburst;
    logic [DATA_WIDTH-1:0]                  Hwdata;
    logic                                   Hready;
    logic [NUM_MASTERS-1:0]                 M_Hresp;
    logic [DATA_WIDTH-1:0]                  Hrdata;
    logic [MW-1:0]                          Hmaster_data;
    logic                                   Data_valid;

    // The mux itself drives the shared bus, so it takes the master side.
    modport master (
        input  Hmaster, M_Haddr, M_Htrans, M_Hwrite, M_Hsize, M_Hburst, M_Hwdata,
               Hready_in, Hresp_in, Hrdata_in,
        output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready, M_Hresp,
               Hrdata, Hmaster_data, Data_valid
    );

    modport slave (
        output Hmaster, M_Haddr, M_Htrans, M_Hwrite, M_Hsize, M_Hburst, M_Hwdata,
               Hready_in, Hresp_in, Hrdata_in,
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready, M_Hresp,
               Hrdata, Hmaster_data, Data_valid
    );
endinterface

// File: rtl/ahb_master_mux.sv
// AHB master multiplexer: routes the arbiter-selected master onto the shared bus,
// tracks the data-phase owner and sequences the two-cycle ERROR response.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_OKAY | normal routing, Htrans passed through from the selected master
// ST_ERR  | second ERROR cycle pending; Htrans forced IDLE to cancel the
//         | erroring master's pipelined transfer
module ahb_master_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input logic              Hclk,
    input logic              Hresetn,
    ahb_master_mux_if.master bus
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [MW:0] NUM_M = (MW + 1)'(NUM_MASTERS);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic {
        ST_OKAY = 1'b0,
        ST_ERR  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [MW-1:0]         sel_addr;
    logic [MW-1:0]         data_owner;
    logic                  data_valid;
    logic [1:0]            htrans_sel;
    logic [1:0]            htrans_out;
    logic [ADDR_WIDTH-1:0] haddr_sel;
    logic [DATA_WIDTH-1:0] hwdata_sel;
    logic [NUM_MASTERS-1:0] resp_vec;

    // Out-of-range indices never come from the arbiter; fall back to master 0.
    always_comb begin
        sel_addr = bus.Hmaster;
        if ({1'b0, bus.Hmaster} >= NUM_M) begin
            sel_addr = '0;
        end
    end

    assign htrans_sel = bus.M_Htrans[sel_addr];
    assign haddr_sel  = bus.M_Haddr[sel_addr];
    assign hwdata_sel = bus.M_Hwdata[data_owner];

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        htrans_out = htrans_sel;
        case (state)
            ST_OKAY: begin
                if (data_valid && bus.Hresp_in && !bus.Hready_in) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                htrans_out = HTRANS_IDLE;
                if (bus.Hready_in) begin
                    state_nxt = ST_OKAY;
                end
            end
            default: begin
                state_nxt = ST_OKAY;
            end
        endcase
    end

    // Data phase advances only on completed cycles; forced IDLE captures as invalid.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            data_owner <= '0;
            data_valid <= 1'b0;
        end else if (bus.Hready_in) begin
            data_owner <= sel_addr;
            data_valid <= htrans_out[1];
        end
    end

    always_comb begin
        resp_vec = '0;
        if (data_valid) begin
            resp_vec[data_owner] = bus.Hresp_in;
        end
    end

    assign bus.Haddr        = haddr_sel;
    assign bus.Htrans       = htrans_out;
    assign bus.Hwrite       = bus.M_Hwrite[sel_addr];
    assign bus.Hsize        = bus.M_Hsize[sel_addr];
    assign bus.Hburst       = bus.M_Hburst[sel_addr];
    assign bus.Hwdata       = hwdata_sel;
    assign bus.Hready       = bus.Hready_in;
    assign bus.M_Hresp      = resp_vec;
    assign bus.Hrdata       = bus.Hrdata_in;
    assign bus.Hmaster_data = data_owner;
    assign bus.Data_valid   = data_valid;
endmodule
